// File: rtl/aq_ifu_pcq_pkg.sv
// Shared definitions for the fetch-PC queue: default geometry, the per-cycle
// operation encoding and a saturating counter helper.
package aq_ifu_pcq_pkg;

    localparam int PCQ_DEPTH_DEF = 4;
    localparam int PCQ_PC_W_DEF  = 64;

    typedef enum logic [1:0] {
        PCQ_OP_NORM    = 2'd0,
        PCQ_OP_FLUSH   = 2'd1,
        PCQ_OP_REISSUE = 2'd2
    } pcq_op_e;

    // A reissue without a returned packet carries no meaning, so it falls to NORM.
    function automatic pcq_op_e pcq_sel_op(input logic flush, input logic reissue,
                                           input logic pop);
        if (flush)
            return PCQ_OP_FLUSH;
        else if (reissue && pop)
            return PCQ_OP_REISSUE;
        else
            return PCQ_OP_NORM;
    endfunction

    function automatic logic [31:0] pcq_sat_inc32(input logic [31:0] val);
        return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/aq_ifu_fetch_pcq_if.sv
// Handshake bundle between pcgen/ICACHE/ipack and the fetch-PC queue.
interface aq_ifu_fetch_pcq_if #(
    parameter int PC_W  = 64,
    parameter int PTR_W = 2
);
    logic              pcq_push_vld;
    logic [PC_W-1:0]   pcq_push_pc;
    logic              pcq_pop_vld;
    logic              pcq_flush;
    logic              pcq_reissue;
    logic              pcq_head_vld;
    logic [PC_W-1:0]   pcq_head_pc;
    logic [PTR_W:0]    pcq_cnt;
    logic              pcq_full;
    logic [PC_W-1:0]   pcq_reissue_pc;
    logic              pcq_reissue_vld;
    logic              pcq_err_ovf;
    logic              pcq_err_unf;

    modport master (
        output pcq_push_vld, pcq_push_pc, pcq_pop_vld, pcq_flush, pcq_reissue,
        input  pcq_head_vld, pcq_head_pc, pcq_cnt, pcq_full, pcq_reissue_pc,
               pcq_reissue_vld, pcq_err_ovf, pcq_err_unf
    );

    modport slave (
        input  pcq_push_vld, pcq_push_pc, pcq_pop_vld, pcq_flush, pcq_reissue,
        output pcq_head_vld, pcq_head_pc, pcq_cnt, pcq_full, pcq_reissue_pc,
               pcq_reissue_vld, pcq_err_ovf, pcq_err_unf
    );
endinterface

// File: rtl/aq_ifu_pcq_ptr.sv
// Wrapping queue pointer; a clear that coincides with an increment lands on 1
// so a push in a flush cycle leaves the write pointer past entry 0.
module aq_ifu_pcq_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             pcgen_cpuclk,
    input  logic             cpurst_b,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge pcgen_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            r_ptr <= '0;
        else if (i_clr)
            r_ptr <= i_inc ? PTR_W'(1) : '0;
        else if (i_inc)
            r_ptr <= r_ptr + PTR_W'(1);
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/aq_ifu_fetch_pcq.sv
// Fetch-PC queue: records granted ICACHE fetch PCs in order, retires on packet return.
// Optional perf counters under `AQ_IFU_PCQ_PERF_EN.
module aq_ifu_fetch_pcq
    import aq_ifu_pcq_pkg::*;
#(
    parameter int DEPTH = PCQ_DEPTH_DEF,
    parameter int PC_W  = PCQ_PC_W_DEF
) (
    input  logic                pcgen_cpuclk,
    input  logic                cpurst_b,
`ifdef AQ_IFU_PCQ_PERF_EN
    output logic [31:0]         pcq_perf_flush_cnt,
    output logic [31:0]         pcq_perf_full_cyc,
`endif
    aq_ifu_fetch_pcq_if.slave   pcq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W:0]   r_cnt;
    logic [PC_W-1:0]  r_reissue_pc;
    logic             r_reissue_vld;
    logic             r_err_ovf;
    logic             r_err_unf;

    pcq_op_e          w_op;
    logic             w_clr;
    logic             w_norm;
    logic             w_pop_acc;
    logic             w_push_acc;
    logic             w_unf;
    logic             w_ovf;
    logic [PTR_W-1:0] w_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_wr_idx;
    logic             w_head_vld;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_full;

    assign w_op   = pcq_sel_op(pcq.pcq_flush, pcq.pcq_reissue, pcq.pcq_pop_vld);
    assign w_clr  = (w_op != PCQ_OP_NORM);
    assign w_norm = (w_op == PCQ_OP_NORM);
    assign w_full = (r_cnt == CNT_FULL);

    // A pop on a full queue frees the slot the same-cycle push needs.
    assign w_pop_acc  = w_norm & pcq.pcq_pop_vld & (r_cnt != '0);
    assign w_unf      = w_norm & pcq.pcq_pop_vld & (r_cnt == '0);
    assign w_push_acc = pcq.pcq_push_vld & (w_clr | ~w_full | w_pop_acc);
    assign w_ovf      = pcq.pcq_push_vld & ~w_push_acc;
    assign w_wr_idx   = w_clr ? '0 : w_wr_ptr;

    aq_ifu_pcq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .pcgen_cpuclk (pcgen_cpuclk),
        .cpurst_b     (cpurst_b),
        .i_clr        (w_clr),
        .i_inc        (w_pop_acc),
        .o_ptr        (w_rd_ptr)
    );

    aq_ifu_pcq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .pcgen_cpuclk (pcgen_cpuclk),
        .cpurst_b     (cpurst_b),
        .i_clr        (w_clr),
        .i_inc        (w_push_acc),
        .o_ptr        (w_wr_ptr)
    );

    always_ff @(posedge pcgen_cpuclk) begin
        if (w_push_acc)
            r_mem[w_wr_idx] <= pcq.pcq_push_pc;
    end

    always_ff @(posedge pcgen_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cnt         <= '0;
            r_reissue_pc  <= '0;
            r_reissue_vld <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_err_unf     <= 1'b0;
        end else begin
            if (w_clr)
                r_cnt <= (PTR_W+1)'(w_push_acc);
            else
                r_cnt <= r_cnt + (PTR_W+1)'(w_push_acc) - (PTR_W+1)'(w_pop_acc);
            r_reissue_vld <= (w_op == PCQ_OP_REISSUE);
            if (w_op == PCQ_OP_REISSUE)
                r_reissue_pc <= w_head_pc;
            if (w_ovf)
                r_err_ovf <= 1'b1;
            r_err_unf <= w_unf;
        end
    end

    // Storage is not reset, so the head is masked whenever the queue is empty.
    assign w_head_vld = (r_cnt != '0);
    assign w_head_pc  = w_head_vld ? r_mem[w_rd_ptr] : '0;

    assign pcq.pcq_head_vld    = w_head_vld;
    assign pcq.pcq_head_pc     = w_head_pc;
    assign pcq.pcq_cnt         = r_cnt;
    assign pcq.pcq_full        = w_full;
    assign pcq.pcq_reissue_pc  = r_reissue_pc;
    assign pcq.pcq_reissue_vld = r_reissue_vld;
    assign pcq.pcq_err_ovf     = r_err_ovf;
    assign pcq.pcq_err_unf     = r_err_unf;

`ifdef AQ_IFU_PCQ_PERF_EN
    logic [31:0] r_perf_flush_cnt;
    logic [31:0] r_perf_full_cyc;

    always_ff @(posedge pcgen_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_perf_flush_cnt <= '0;
            r_perf_full_cyc  <= '0;
        end else begin
            if (w_clr)
                r_perf_flush_cnt <= pcq_sat_inc32(r_perf_flush_cnt);
            if (w_full)
                r_perf_full_cyc <= pcq_sat_inc32(r_perf_full_cyc);
        end
    end

    assign pcq_perf_flush_cnt = r_perf_flush_cnt;
    assign pcq_perf_full_cyc  = r_perf_full_cyc;
`endif

endmodule

// File: doc/aq_ifu_fetch_pcq.md
Name: aq_ifu_fetch_pcq

Overview:
- Fetch-PC queue directly downstream of the PC generator; sits between pcgen and the ICACHE return path.
- Records the PC of every granted ICACHE request in issue order and retires one entry per returned instruction packet.
- Supplies the head PC, i.e. the PC of the oldest outstanding fetch, to ipack/predecode.
- Flushes on change of flow and raises back-pressure when the outstanding-fetch limit is reached.

Parameters:
- DEPTH, 4, entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer width.
- PC_W, 64, PC width.

Ports:
- pcgen_cpuclk  in  1  gated PCGEN clock.
- cpurst_b  in  1  reset.
- pcq_push_vld  in  1  ICACHE grant; push request.
- pcq_push_pc  in  PC_W  granted fetch VA (pcgen_icache_va).
- pcq_pop_vld  in  1  ICACHE instruction packet valid; retire head.
- pcq_flush  in  1  change of flow (pcgen_icache_chgflw_vld).
- pcq_reissue  in  1  ipack reissue of the current returned packet.
- pcq_head_vld  out  1  queue non-empty.
- pcq_head_pc  out  PC_W  PC of oldest entry.
- pcq_cnt  out  PTR_W+1  occupancy.
- pcq_full  out  1  cnt==DEPTH; stall to pcgen.
- pcq_reissue_pc  out  PC_W  PC to refetch, valid the cycle after pcq_reissue.
- pcq_reissue_vld  out  1  registered pulse.
- pcq_err_ovf  out  1  sticky overflow error.
- pcq_err_unf  out  1  one-cycle underflow pulse.

Behaviour:
- Reset is cpurst_b, asynchronous, active-low; clock is pcgen_cpuclk. Both are fixed for this block.
- Reset values:
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - All outputs 0; head_pc=0.
  - Entry storage has no reset. head_pc is masked to 0 when empty.
- Storage: circular array of DEPTH x PC_W. wr_ptr and rd_ptr are PTR_W bits, wrap modulo DEPTH. cnt is tracked separately.
- Latency:
  - A push is visible at head on the next cycle, when the queue was empty.
  - There is no combinational bypass from push_pc to head_pc.
- Per-cycle priority, evaluated in this order:
  1. pcq_flush:
     - rd_ptr=wr_ptr=0, cnt=0. Any pop in the same cycle is ignored.
     - A push in the same cycle is written to entry 0, giving cnt=1. The granted fetch belongs to the new flow.
  2. pcq_reissue with pcq_pop_vld:
     - reissue_pc <= head_pc; reissue_vld <= 1.
     - Queue is cleared as in flush, including the same-cycle push rule.
  3. pcq_reissue without pop: ignored. Reissue is only meaningful with a returned packet.
  4. Normal operation:
     - Pop when cnt>0: rd_ptr++.
     - Push when cnt<DEPTH, or when cnt==DEPTH with a pop in the same cycle: write at wr_ptr, then wr_ptr++.
     - cnt += push_accepted - pop_accepted.
- Boundary cases:
  - Push when full without a pop: push dropped; pcq_err_ovf set and held until reset.
  - Pop when empty: ignored; pcq_err_unf pulses high for one cycle, registered.
  - Push and pop together when empty: push accepted, pop is an underflow; cnt=1.
- pcq_full is combinational from cnt. pcgen must not assert a grant when pcq_full is high, unless a pop is in the same cycle.
- A gated clock can stop only when there is no push, pop, flush or reissue. State holds while the clock is stopped.

Optional Feature:
- Macro: AQ_IFU_PCQ_PERF_EN.
- When defined:
  - Adds output pcq_perf_flush_cnt [31:0], a saturating count of flush events (flush, or reissue with pop).
  - Adds output pcq_perf_full_cyc [31:0], a saturating count of cycles with pcq_full=1.
  - Both reset to 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package aq_ifu_pcq_pkg holds:
  - Defaults for DEPTH and PC_W.
  - Encodings of the priority decision: PCQ_OP_FLUSH, PCQ_OP_REISSUE, PCQ_OP_NORM.
- Sub-module aq_ifu_pcq_ptr is natural. It is instantiated twice, for rd_ptr and wr_ptr. Function: wrapping increment with clear.

Test Plan:
- Ordering: push 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, then pop three -> head_pc sequence 0x8000_0000/04/08, cnt 3->0, head_vld drops after the third pop.
- Full and back-pressure (DEPTH=4):
  - Push 4 -> full=1.
  - Fifth push alone -> dropped, err_ovf=1 sticky.
  - Push with pop while full -> accepted, cnt stays 4.
- Flush with push: cnt=3, then flush and push 0x1000 in the same cycle -> next cycle cnt=1, head_pc=0x1000, no underflow error.
- Reissue:
  - head=0x2040, cnt=2, then reissue with pop -> next cycle reissue_vld=1, reissue_pc=0x2040, cnt=0.
  - Reissue without pop -> no effect.
- Underflow: pop when empty -> err_unf one-cycle pulse, cnt stays 0; push and pop together when empty -> cnt=1.
- Reset mid-operation: cnt=3, assert cpurst_b low asynchronously -> all outputs 0 immediately; after release, a first push at 0x40 gives head_pc=0x40.
